// File: rtl/mac_dot_pkg.sv
// Shared types and helpers for the multi-lane dot-product MAC.
// Optional build macro: MAC_SAT_EN (clamp out-of-range results instead of wrapping).
package mac_dot_pkg;

    // Ceiling log2 for elaboration-time width derivation.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = 1; v < value; v = v << 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Accumulator width: full product, growth of the lane sum, plus headroom.
    function automatic int acc_width(input int data_w, input int lanes, input int guard);
        return 2 * data_w + clog2(lanes) + guard;
    endfunction

    // Per-stage control flags carried alongside the datapath.
    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } stage_flags_t;

    // Output selection for the result formatter.
    typedef enum logic [1:0] {
        RES_PASS = 2'd0,
        RES_MAX  = 2'd1,
        RES_MIN  = 2'd2
    } res_sel_t;

`ifdef MAC_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    // Saturate-or-truncate decision: clamp only when saturation is built in.
    function automatic res_sel_t sat_select(input logic above, input logic below, input logic sat_en);
        if (sat_en && above) begin
            return RES_MAX;
        end else if (sat_en && below) begin
            return RES_MIN;
        end
        return RES_PASS;
    endfunction

endpackage

// File: rtl/mac_adder_tree.sv
// Registered sum of LANES signed products, sign-extended to ACC_W.
// Flags travel with the sum so the accumulator sees them aligned.
module mac_adder_tree
    import mac_dot_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int PROD_W = 32,
    parameter int ACC_W  = 38
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     en,
    input  logic [LANES*PROD_W-1:0]  products,
    input  stage_flags_t             flags_in,
    output logic signed [ACC_W-1:0]  sum,
    output stage_flags_t             flags_out
);

    logic signed [ACC_W-1:0] sum_d;

    // Combinational lane sum; written as a loop, synthesis balances it into a tree.
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < LANES; i++) begin
            sum_d = sum_d + ACC_W'(signed'(products[i*PROD_W +: PROD_W]));
        end
    end

    // Register the sum and its flags; hold under stall.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sum       <= '0;
            flags_out <= '0;
        end else if (en) begin
            sum       <= sum_d;
            flags_out <= flags_in;
        end
    end

endmodule

// File: rtl/mac_dot_lanes.sv
// LANES-wide signed multiply, adder tree and framed accumulator with
// valid/ready flow control. One result per group of vec_len beats.
// Optional build macro: MAC_SAT_EN (clamp out-of-range results to OUT_W limits).
//
// Handshake: a beat transfers on a rising edge where ivalid && oready; a result
// transfers where ovalid && iready. A single enable (iready | ~ovalid) advances
// every pipeline register, so a pending result freezes the whole pipe and
// dataout/ovalid stay put until taken.
module mac_dot_lanes
    import mac_dot_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int LANES  = 4,
    parameter int LEN_W  = 8,
    parameter int GUARD  = 4,
    parameter int OUT_W  = 32
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic                      ivalid,
    output logic                      oready,
    input  logic                      control,
    input  logic [LEN_W-1:0]          vec_len,
    input  logic [LANES*DATA_W-1:0]   datainA,
    input  logic [LANES*DATA_W-1:0]   datainB,
    output logic                      ovalid,
    input  logic                      iready,
    output logic [OUT_W-1:0]          dataout,
    output logic                      overflow
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int ACC_W  = acc_width(DATA_W, LANES, GUARD);
    localparam int EXT_W  = (ACC_W > OUT_W) ? ACC_W : OUT_W;

    localparam logic signed [EXT_W-1:0] OUT_MAX = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] OUT_MIN = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic en;
    logic accept;

    assign en     = iready | ~ovalid;
    assign oready = en;
    assign accept = ivalid && en;

    // ---------------- framing ----------------
    logic [LEN_W-1:0] count_q, count_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] len_eff;
    stage_flags_t     beat_flags;

    // Classify the accepted beat: group start, group member, or idle discard.
    always_comb begin
        beat_flags = '0;
        count_d    = count_q;
        len_d      = len_q;
        len_eff    = (vec_len == '0) ? LEN_W'(1) : vec_len;
        if (accept) begin
            if (control) begin
                beat_flags.valid = 1'b1;
                beat_flags.first = 1'b1;
                beat_flags.last  = (len_eff == LEN_W'(1));
                len_d            = len_eff;
                count_d          = (len_eff == LEN_W'(1)) ? '0 : LEN_W'(1);
            end else if (count_q != '0) begin
                beat_flags.valid = 1'b1;
                beat_flags.last  = (count_q == len_q - LEN_W'(1));
                count_d          = beat_flags.last ? '0 : count_q + LEN_W'(1);
            end
        end
    end

    // Beat counter and latched group length; zero count means idle.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
            len_q   <= '0;
        end else begin
            count_q <= count_d;
            len_q   <= len_d;
        end
    end

    // ---------------- S1: products ----------------
    logic [LANES*PROD_W-1:0] prod_d, prod_q;
    stage_flags_t            s1_flags;

    // Per-lane signed multiply.
    always_comb begin
        prod_d = '0;
        for (int i = 0; i < LANES; i++) begin
            prod_d[i*PROD_W +: PROD_W] = PROD_W'(signed'(datainA[i*DATA_W +: DATA_W]))
                                       * PROD_W'(signed'(datainB[i*DATA_W +: DATA_W]));
        end
    end

    // Product register; an enabled cycle without a kept beat loads an empty slot.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            prod_q   <= '0;
            s1_flags <= '0;
        end else if (en) begin
            prod_q   <= prod_d;
            s1_flags <= beat_flags;
        end
    end

    // ---------------- S2: adder tree ----------------
    logic signed [ACC_W-1:0] s2_sum;
    stage_flags_t            s2_flags;

    mac_adder_tree #(
        .LANES  (LANES),
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_tree (
        .clock     (clock),
        .resetn    (resetn),
        .en        (en),
        .products  (prod_q),
        .flags_in  (s1_flags),
        .sum       (s2_sum),
        .flags_out (s2_flags)
    );

    // ---------------- S3: accumulate and format ----------------
    logic signed [ACC_W-1:0] acc_q, acc_next;
    logic signed [EXT_W-1:0] res_ext;
    logic                    above, below;
    res_sel_t                res_sel;
    logic [OUT_W-1:0]        out_d;

    // Next accumulator value and its range check / formatting.
    always_comb begin
        acc_next = s2_flags.first ? s2_sum : acc_q + s2_sum;
        res_ext  = EXT_W'(acc_next);
        above    = (res_ext > OUT_MAX);
        below    = (res_ext < OUT_MIN);
        res_sel  = sat_select(above, below, SAT_EN);
        case (res_sel)
            RES_MAX: out_d = {1'b0, {(OUT_W-1){1'b1}}};
            RES_MIN: out_d = {1'b1, {(OUT_W-1){1'b0}}};
            default: out_d = res_ext[OUT_W-1:0];
        endcase
    end

    // Accumulator; the first flag restarts it so groups can run back to back.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            acc_q <= '0;
        end else if (en && s2_flags.valid) begin
            acc_q <= acc_next;
        end
    end

    // Result register: load on a group's last beat, clear valid once taken.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ovalid   <= 1'b0;
            dataout  <= '0;
            overflow <= 1'b0;
        end else if (en) begin
            if (s2_flags.valid && s2_flags.last) begin
                ovalid   <= 1'b1;
                dataout  <= out_d;
                overflow <= above | below;
            end else begin
                ovalid   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mac_dot_lanes.sv
// Directed bench for mac_dot_lanes: a driver pushes hand-computed results into
// an expected queue, a monitor pops and compares on each result handshake.
module tb_mac_dot_lanes;

    localparam int DATA_W = 16;
    localparam int LANES  = 4;
    localparam int LEN_W  = 8;
    localparam int GUARD  = 4;
    localparam int OUT_W  = 32;
    localparam int W      = LANES * DATA_W;

    logic              clock;
    logic              resetn;
    logic              ivalid;
    logic              oready;
    logic              control;
    logic [LEN_W-1:0]  vec_len;
    logic [W-1:0]      data_a;
    logic [W-1:0]      data_b;
    logic              ovalid;
    logic              iready;
    logic [OUT_W-1:0]  dataout;
    logic              overflow;

    int checks = 0;
    int errors = 0;

    logic [OUT_W:0] exp_q[$];

    logic           held;
    logic [OUT_W:0] held_val;

    mac_dot_lanes #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .LEN_W  (LEN_W),
        .GUARD  (GUARD),
        .OUT_W  (OUT_W)
    ) dut (
        .clock    (clock),
        .resetn   (resetn),
        .ivalid   (ivalid),
        .oready   (oready),
        .control  (control),
        .vec_len  (vec_len),
        .datainA  (data_a),
        .datainB  (data_b),
        .ovalid   (ovalid),
        .iready   (iready),
        .dataout  (dataout),
        .overflow (overflow)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- helpers ----------------
    function automatic logic [W-1:0] pack4(input int v0, input int v1, input int v2, input int v3);
        return {16'(v3), 16'(v2), 16'(v1), 16'(v0)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one beat and hold it until the DUT takes it (bounded wait).
    task automatic send_beat(input logic ctrl, input logic [LEN_W-1:0] len,
                             input logic [W-1:0] a, input logic [W-1:0] b);
        int  waited;
        bit  done;
        waited  = 0;
        done    = 0;
        control = ctrl;
        vec_len = len;
        data_a  = a;
        data_b  = b;
        ivalid  = 1'b1;
        while (!done) begin
            @(negedge clock);
            if (oready) done = 1;
            @(posedge clock);
            #1;
            if (!done) begin
                waited++;
                if (waited > 200) begin
                    checks++;
                    errors++;
                    $display("FAIL send_timeout: got no accept expected accept within 200 cycles");
                    done = 1;
                end
            end
        end
        ivalid  = 1'b0;
        control = 1'b0;
    endtask

    // Wait for all expected results to be consumed (bounded).
    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clock);
            #1;
            n++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
        repeat (3) @(posedge clock);
        #1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clock) begin
        if (!resetn) begin
            held = 1'b0;
        end else begin
            if (held) begin
                checks++;
                if (!ovalid || {overflow, dataout} !== held_val) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%0b %0h expected v=1 %0h", ovalid, {overflow, dataout}, held_val);
                end
            end
            if (ovalid && iready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result: got %0h expected no result", {overflow, dataout});
                end else begin
                    logic [OUT_W:0] e;
                    e = exp_q.pop_front();
                    if ({overflow, dataout} !== e) begin
                        errors++;
                        $display("FAIL result: got ovf=%0b data=%0h expected ovf=%0b data=%0h",
                                 overflow, dataout, e[OUT_W], e[OUT_W-1:0]);
                    end
                end
            end
            held     = ovalid && !iready;
            held_val = {overflow, dataout};
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        resetn  = 1'b0;
        ivalid  = 1'b0;
        control = 1'b0;
        vec_len = '0;
        data_a  = '0;
        data_b  = '0;
        iready  = 1'b1;
        held    = 1'b0;
        held_val = '0;
        repeat (3) @(posedge clock);
        #1;
        resetn = 1'b1;
        @(posedge clock);
        #1;

        // Reset state.
        check("reset_ovalid", 64'(ovalid), 64'd0);
        check("reset_dataout", 64'(dataout), 64'd0);
        check("reset_overflow", 64'(overflow), 64'd0);
        check("reset_oready", 64'(oready), 64'd1);

        // Single-beat group: 1*5+2*6+3*7+4*8 = 70, visible on the third edge.
        exp_q.push_back({1'b0, 32'd70});
        send_beat(1'b1, 8'd1, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8));
        check("latency_edge1", 64'(ovalid), 64'd0);
        @(posedge clock); #1;
        check("latency_edge2", 64'(ovalid), 64'd0);
        @(posedge clock); #1;
        check("latency_edge3", 64'(ovalid), 64'd1);
        drain("drain_single");

        // Three beats of 2*2 on four lanes: 3*16 = 48; then vec_len=0 acts as 1: 16.
        exp_q.push_back({1'b0, 32'd48});
        exp_q.push_back({1'b0, 32'd16});
        send_beat(1'b1, 8'd3, pack4(2, 2, 2, 2), pack4(2, 2, 2, 2));
        send_beat(1'b0, 8'd0, pack4(2, 2, 2, 2), pack4(2, 2, 2, 2));
        send_beat(1'b0, 8'd0, pack4(2, 2, 2, 2), pack4(2, 2, 2, 2));
        send_beat(1'b1, 8'd0, pack4(2, 2, 2, 2), pack4(2, 2, 2, 2));
        drain("drain_len3_len0");

        // Backpressure: 12, then -40 twice = -80, then 10000-10000+49+0 = 49.
        exp_q.push_back({1'b0, 32'd12});
        exp_q.push_back({1'b0, 32'hFFFF_FFB0});
        exp_q.push_back({1'b0, 32'd49});
        iready = 1'b0;
        fork
            begin
                send_beat(1'b1, 8'd1, pack4(1, 1, 1, 1), pack4(3, 3, 3, 3));
                send_beat(1'b1, 8'd2, pack4(-2, -2, -2, -2), pack4(5, 5, 5, 5));
                send_beat(1'b0, 8'd0, pack4(-2, -2, -2, -2), pack4(5, 5, 5, 5));
                send_beat(1'b1, 8'd1, pack4(100, -100, 7, 0), pack4(100, 100, 7, 9));
            end
            begin
                repeat (6) @(posedge clock);
                #1;
                check("stall_oready", 64'(oready), 64'd0);
                check("stall_ovalid", 64'(ovalid), 64'd1);
                check("stall_dataout", 64'(dataout), 64'd12);
                repeat (2) @(posedge clock);
                #1;
                iready = 1'b1;
            end
        join
        drain("drain_stall");

        // Restart: control on beat 2 abandons the len-4 group; new group 36+36 = 72.
        exp_q.push_back({1'b0, 32'd72});
        send_beat(1'b1, 8'd4, pack4(1, 1, 1, 1), pack4(1, 1, 1, 1));
        send_beat(1'b1, 8'd2, pack4(3, 3, 3, 3), pack4(3, 3, 3, 3));
        send_beat(1'b0, 8'd0, pack4(3, 3, 3, 3), pack4(3, 3, 3, 3));
        drain("drain_restart");

        // Back-to-back groups: 4+4 = 8, then (-1*-1)*4*2 = 8.
        exp_q.push_back({1'b0, 32'd8});
        exp_q.push_back({1'b0, 32'd8});
        send_beat(1'b1, 8'd2, pack4(1, 1, 1, 1), pack4(1, 1, 1, 1));
        send_beat(1'b0, 8'd0, pack4(1, 1, 1, 1), pack4(1, 1, 1, 1));
        send_beat(1'b1, 8'd2, pack4(-1, -1, -1, -1), pack4(-1, -1, -1, -1));
        send_beat(1'b0, 8'd0, pack4(-1, -1, -1, -1), pack4(-1, -1, -1, -1));
        drain("drain_b2b");

        // Idle beats without control are discarded; then 1*2*4 = 8.
        exp_q.push_back({1'b0, 32'd8});
        send_beat(1'b0, 8'd5, pack4(999, 999, 999, 999), pack4(77, 77, 77, 77));
        send_beat(1'b0, 8'd1, pack4(-5, 6, -7, 8), pack4(9, 9, 9, 9));
        send_beat(1'b1, 8'd1, pack4(1, 1, 1, 1), pack4(2, 2, 2, 2));
        drain("drain_idle");

        // Full scale: 8*32767^2 = 8589410312 = 0x1_FFF8_0008, outside 32-bit signed.
`ifdef MAC_SAT_EN
        exp_q.push_back({1'b1, 32'h7FFF_FFFF});
`else
        exp_q.push_back({1'b1, 32'hFFF8_0008});
`endif
        send_beat(1'b1, 8'd2, pack4(32767, 32767, 32767, 32767), pack4(32767, 32767, 32767, 32767));
        send_beat(1'b0, 8'd0, pack4(32767, 32767, 32767, 32767), pack4(32767, 32767, 32767, 32767));
        drain("drain_overflow");

        // Reset mid-group: everything cleared, partial group lost.
        send_beat(1'b1, 8'd3, pack4(4, 4, 4, 4), pack4(4, 4, 4, 4));
        send_beat(1'b0, 8'd0, pack4(4, 4, 4, 4), pack4(4, 4, 4, 4));
        resetn = 1'b0;
        @(posedge clock);
        #1;
        check("midreset_ovalid", 64'(ovalid), 64'd0);
        check("midreset_dataout", 64'(dataout), 64'd0);
        check("midreset_overflow", 64'(overflow), 64'd0);
        resetn = 1'b1;
        @(posedge clock);
        #1;
        exp_q.push_back({1'b0, 32'd4});
        send_beat(1'b0, 8'd0, pack4(4, 4, 4, 4), pack4(4, 4, 4, 4));
        send_beat(1'b1, 8'd1, pack4(1, 1, 1, 1), pack4(1, 1, 1, 1));
        drain("drain_after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
